wb_framebuffer: RTL and testbench

- Parametrised, double-buffered BRAM framebuffer with a pipelined Wishbone slave port (CPU side) and a dedicated read-only scan port (matrix driver side).
- The CPU writes and reads the back buffer. The scanner reads the front buffer.
- A swap requested by the CPU takes effect only at a frame boundary signalled by the scanner, so the display never shows a partial frame.
- Sits between the LiteX SoC bus and the matrix scan logic.

---
 rtl/wb_framebuffer.sv | 114 +++++++++++
 tb/tb_wb_framebuffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_framebuffer.sv
// Double-buffered framebuffer: Wishbone (pipelined) access to the back buffer,
// a read-only scan port on the front buffer, and frame-synchronous buffer swap.
module wb_framebuffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 64,
    localparam int unsigned SCAN_AW   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [ADDR_WIDTH-1:0]   wb_addr,
    input  logic [DATA_WIDTH-1:0]   wb_wdata,
    input  logic [DATA_WIDTH/8-1:0] wb_sel,
    output logic                    wb_stall,
    output logic                    wb_ack,
    output logic [DATA_WIDTH-1:0]   wb_rdata,
    input  logic [SCAN_AW-1:0]      scan_addr,
    output logic [DATA_WIDTH-1:0]   scan_data,
    input  logic                    frame_done,
    output logic                    front_sel
);
    localparam int unsigned SEL_W     = DATA_WIDTH / 8;
    localparam int unsigned MEM_WORDS = 2 * DEPTH;
    localparam int unsigned MEM_AW    = $clog2(MEM_WORDS);
    localparam int unsigned FRAME_W   = 16;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("wb_framebuffer: DATA_WIDTH must be a multiple of 8");
    end
    if (64'(DEPTH) + 64'd2 > (64'd1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("wb_framebuffer: DEPTH+2 must fit in the Wishbone address space");
    end

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic               swap_pending;
    logic [FRAME_W-1:0] frame_count;
    logic               ack_q;
    logic               in_buf;
    logic               is_ctrl;
    logic               is_frame;
    logic               accept;
    logic               ctrl_set;
    logic               swap_fire;
    logic [MEM_AW-1:0]  wb_idx;
    logic [MEM_AW-1:0]  scan_idx;

    // Address decode; back buffer is the one not being displayed.
    assign in_buf   = wb_addr < ADDR_WIDTH'(DEPTH);
    assign is_ctrl  = wb_addr == ADDR_WIDTH'(DEPTH);
    assign is_frame = wb_addr == ADDR_WIDTH'(DEPTH + 1);
    assign wb_idx   = (front_sel ? MEM_AW'(0) : MEM_AW'(DEPTH)) + MEM_AW'(wb_addr);
    assign scan_idx = (front_sel ? MEM_AW'(DEPTH) : MEM_AW'(0)) + MEM_AW'(scan_addr);

    // Back-buffer traffic is held off while a swap waits, so the buffer that
    // is about to become visible cannot be modified mid-swap.
    assign wb_stall  = swap_pending && in_buf;
    assign accept    = wb_cyc && wb_stb && !wb_stall;
    assign ctrl_set  = accept && wb_we && is_ctrl && wb_sel[0] && wb_wdata[0];
    assign swap_fire = frame_done && swap_pending;

    // Ack is gated by the live cycle signal so an aborted cycle sees no ack.
    assign wb_ack = ack_q && wb_cyc;

    // Byte-lane writes into the back buffer.
    always_ff @(posedge clk) begin
        if (accept && wb_we && in_buf) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (wb_sel[b]) begin
                    mem[wb_idx][8*b +: 8] <= wb_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q        <= 1'b0;
            wb_rdata     <= '0;
            scan_data    <= '0;
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            frame_count  <= '0;
        end else begin
            ack_q     <= accept;
            scan_data <= mem[scan_idx];

            if (accept && !wb_we) begin
                if (in_buf) begin
                    wb_rdata <= mem[wb_idx];
                end else if (is_ctrl) begin
                    wb_rdata <= DATA_WIDTH'({swap_pending, front_sel});
                end else if (is_frame) begin
                    wb_rdata <= DATA_WIDTH'(frame_count);
                end else begin
                    wb_rdata <= '0;
                end
            end

            // A completing swap takes priority; a request while pending is a no-op.
            if (swap_fire) begin
                front_sel    <= ~front_sel;
                swap_pending <= 1'b0;
                frame_count  <= frame_count + FRAME_W'(1);
            end else if (ctrl_set) begin
                swap_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_framebuffer.sv
// Directed bench for wb_framebuffer: byte lanes, bursts, swap timing, abort, async reset.
module tb_wb_framebuffer;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned SAW   = 6;

    logic            clk;
    logic            reset;
    logic            wb_cyc;
    logic            wb_stb;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_wdata;
    logic [DW/8-1:0] wb_sel;
    logic            wb_stall;
    logic            wb_ack;
    logic [DW-1:0]   wb_rdata;
    logic [SAW-1:0]  scan_addr;
    logic [DW-1:0]   scan_data;
    logic            frame_done;
    logic            front_sel;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    wb_framebuffer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_wdata   (wb_wdata),
        .wb_sel     (wb_sel),
        .wb_stall   (wb_stall),
        .wb_ack     (wb_ack),
        .wb_rdata   (wb_rdata),
        .scan_addr  (scan_addr),
        .scan_data  (scan_data),
        .frame_done (frame_done),
        .front_sel  (front_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Single transfer; ack must appear exactly one cycle after acceptance.
    task automatic xfer(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] sel, input logic fd, output logic [31:0] data);
        int n;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr;
        wb_wdata = wd; wb_sel = sel; frame_done = fd;
        n = 0;
        @(negedge clk);
        while (wb_stall && n < 32) begin
            @(negedge clk);
            n++;
        end
        if (n == 32) check("stall_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        wb_stb = 1'b0; frame_done = 1'b0;
        @(negedge clk);
        check("ack", 32'(wb_ack), 32'd1);
        data = wb_rdata;
        @(posedge clk); #1;
        wb_cyc = 1'b0;
    endtask

    task automatic pulse_frame_done();
        frame_done = 1'b1;
        @(posedge clk); #1;
        frame_done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = '0;
        wb_wdata = '0; wb_sel = '0; scan_addr = '0; frame_done = 1'b0;
        @(posedge clk); #1;
        check("rst_ack", 32'(wb_ack), 32'd0);
        check("rst_rdata", wb_rdata, 32'd0);
        check("rst_scan", scan_data, 32'd0);
        check("rst_front", 32'(front_sel), 32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // Byte-lane merge into buffer 1 (back buffer while front_sel=0)
        xfer(1'b1, 8'd3, 32'hAABBCCDD, 4'hF, 1'b0, rd);
        xfer(1'b1, 8'd3, 32'h11223344, 4'h5, 1'b0, rd);
        xfer(1'b0, 8'd3, 32'h0, 4'h0, 1'b0, rd);
        check("byte_lane", rd, 32'hAA22CC44);

        // Back-to-back write burst then read burst
        wb_cyc = 1'b1; wb_we = 1'b1; wb_sel = 4'hF;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                wb_stb = 1'b1; wb_addr = 8'(i); wb_wdata = 32'(i) * 32'h01010101;
            end else begin
                wb_stb = 1'b0;
            end
            @(negedge clk);
            if (i < 8) check("burst_wr_stall", 32'(wb_stall), 32'd0);
            if (i > 0) check("burst_wr_ack", 32'(wb_ack), 32'd1);
            @(posedge clk); #1;
        end
        wb_we = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                wb_stb = 1'b1; wb_addr = 8'(i);
            end else begin
                wb_stb = 1'b0;
            end
            @(negedge clk);
            if (i < 8) check("burst_rd_stall", 32'(wb_stall), 32'd0);
            if (i > 0) begin
                check("burst_rd_ack", 32'(wb_ack), 32'd1);
                check("burst_rd_data", wb_rdata, 32'(i - 1) * 32'h01010101);
            end
            @(posedge clk); #1;
        end
        wb_cyc = 1'b0;

        // Swap flow
        xfer(1'b1, 8'd0, 32'h55, 4'hF, 1'b0, rd);
        xfer(1'b1, 8'd64, 32'h1, 4'h1, 1'b0, rd);
        xfer(1'b0, 8'd64, 32'h0, 4'h0, 1'b0, rd);
        check("ctrl_pending", rd, 32'd2);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 8'd0; wb_wdata = 32'hBAD;
        @(negedge clk);
        check("stall_set", 32'(wb_stall), 32'd1);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        pulse_frame_done();
        check("swap_front", 32'(front_sel), 32'd1);
        check("swap_stall_drop", 32'(wb_stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("scan_new_front", scan_data, 32'h55);
        xfer(1'b0, 8'd65, 32'h0, 4'h0, 1'b0, rd);
        check("frame_1", rd, 32'd1);

        // Swap request coincident with frame_done only sets pending
        xfer(1'b1, 8'd64, 32'h1, 4'h1, 1'b1, rd);
        check("coinc_front", 32'(front_sel), 32'd1);
        xfer(1'b0, 8'd64, 32'h0, 4'h0, 1'b0, rd);
        check("coinc_ctrl", rd, 32'd3);
        pulse_frame_done();
        check("coinc_swap", 32'(front_sel), 32'd0);
        xfer(1'b0, 8'd65, 32'h0, 4'h0, 1'b0, rd);
        check("frame_2", rd, 32'd2);

        // Repeated request while pending counts once
        xfer(1'b1, 8'd64, 32'h1, 4'h1, 1'b0, rd);
        xfer(1'b1, 8'd64, 32'h1, 4'h1, 1'b0, rd);
        xfer(1'b0, 8'd64, 32'h0, 4'h0, 1'b0, rd);
        check("dbl_ctrl", rd, 32'd2);
        pulse_frame_done();
        xfer(1'b0, 8'd65, 32'h0, 4'h0, 1'b0, rd);
        check("frame_3", rd, 32'd3);
        pulse_frame_done();
        xfer(1'b0, 8'd65, 32'h0, 4'h0, 1'b0, rd);
        check("frame_idle_fd", rd, 32'd3);
        xfer(1'b0, 8'd64, 32'h0, 4'h0, 1'b0, rd);
        check("ctrl_idle", rd, 32'd1);

        // Unmapped read and aborted cycle
        xfer(1'b0, 8'd69, 32'h0, 4'h0, 1'b0, rd);
        check("unmapped", rd, 32'd0);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 8'd1;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        check("abort_ack", 32'(wb_ack), 32'd0);

        // Async reset during a pending swap with a read in flight
        xfer(1'b1, 8'd5, 32'hDEADBEEF, 4'hF, 1'b0, rd);
        xfer(1'b1, 8'd64, 32'h1, 4'h1, 1'b0, rd);
        scan_addr = 6'd5;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 8'd65;
        @(posedge clk); #1;
        wb_stb = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ack", 32'(wb_ack), 32'd0);
        check("mid_rst_rdata", wb_rdata, 32'd0);
        check("mid_rst_front", 32'(front_sel), 32'd0);
        check("mid_rst_scan", scan_data, 32'd0);
        wb_cyc = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 8'd64, 32'h0, 4'h0, 1'b0, rd);
        check("post_rst_ctrl", rd, 32'd0);
        xfer(1'b0, 8'd65, 32'h0, 4'h0, 1'b0, rd);
        check("post_rst_frame", rd, 32'd0);
        xfer(1'b0, 8'd3, 32'h0, 4'h0, 1'b0, rd);
        check("post_rst_mem", rd, 32'h03030303);
        check("post_rst_scan", scan_data, 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
